// File: rtl/program_loader.sv
// Byte-stream program loader: parses a sync/count/payload/checksum frame and
// writes 64-bit instruction words into program memory, then enables the core.
module program_loader #(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              run,
  output logic              error
);

  typedef enum logic [2:0] {SYNC, LEN, DATA, CHECK, DONE, ERR} state_e;

  localparam logic [7:0]    SYNC_BYTE = 8'hA5;
  localparam logic [31:0]   MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = 1;

  state_e              state_q, state_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         count_q, count_d;
  logic [ADDR_W:0]     word_idx_q, word_idx_d;
  logic [WORD_W-9:0]   partial_q, partial_d;
  logic [7:0]          csum_q, csum_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;

  logic loading;
  logic accept;

  assign loading = (state_q == SYNC) || (state_q == LEN) ||
                   (state_q == DATA) || (state_q == CHECK);
  assign accept  = in_valid && loading && !rst;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    partial_d  = partial_q;
    csum_d     = csum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (accept) begin
      case (state_q)
        SYNC: begin
          if (in_data == SYNC_BYTE) begin
            state_d    = LEN;
            byte_cnt_d = '0;
          end
        end
        LEN: begin
          count_d    = {count_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd2) begin
            byte_cnt_d = '0;
            if (count_d == '0)
              state_d = CHECK;
            else if (32'(count_d) > MAX_WORDS)
              state_d = ERR;
            else
              state_d = DATA;
          end
        end
        DATA: begin
          partial_d  = {partial_q[WORD_W-17:0], in_data};
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            // Word completes on the 8th byte; the write is registered so it
            // appears one cycle later with the pre-increment index.
            wr_en_d    = 1'b1;
            wr_data_d  = {partial_q, in_data};
            wr_addr_d  = word_idx_q[ADDR_W-1:0];
            word_idx_d = word_idx_q + IDX_ONE;
            if (32'(word_idx_d) == 32'(count_q))
              state_d = CHECK;
          end
        end
        CHECK: begin
          state_d = (in_data == csum_q) ? DONE : ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SYNC;
      byte_cnt_q <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      partial_q  <= '0;
      csum_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      partial_q  <= partial_d;
      csum_q     <= csum_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Outputs are forced to their idle values while rst is high, whatever state
  // the registers still hold from before the reset edge.
  assign in_ready = loading || rst;
  assign wr_en    = wr_en_q && !rst;
  assign wr_addr  = rst ? '0 : wr_addr_q;
  assign wr_data  = rst ? '0 : wr_data_q;
  assign run      = (state_q == DONE) && !rst;
  assign error    = (state_q == ERR) && !rst;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are built from word lists, the
// expected writes queued at issue time and checked by an independent monitor.
module tb_program_loader;

  localparam int ADDR_W = 20;
  localparam int WORD_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              run;
  logic              error;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_data_q[$];
  logic [63:0] exp_addr_q[$];
  logic [63:0] frame_words[$];

  program_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .run      (run),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_wr_en", 64'd1, 64'd0);
      end else begin
        check("wr_addr", 64'(wr_addr), exp_addr_q.pop_front());
        check("wr_data", wr_data, exp_data_q.pop_front());
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    repeat (g) idle();
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b, -1);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wr_en",    64'(wr_en),    64'd0);
    check("rst_run",      64'(run),      64'd0);
    check("rst_error",    64'(error),    64'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_wr_en",    64'(wr_en),    64'd0);
    check("post_rst_wr_addr",  64'(wr_addr),  64'd0);
    check("post_rst_wr_data",  wr_data,       64'd0);
    check("post_rst_run",      64'(run),      64'd0);
    check("post_rst_error",    64'(error),    64'd0);
    @(posedge clk); #1;
  endtask

  // Sends a frame of cnt words taken from frame_words; cs_flip corrupts the checksum.
  task automatic run_frame(input logic [23:0] cnt, input logic [7:0] cs_flip, input int gap);
    logic [7:0]  cs;
    logic [63:0] wd;
    logic [7:0]  by;
    bit          ovf;
    bit          good;
    cs   = 8'h00;
    ovf  = (32'(cnt) > (32'd1 << ADDR_W));
    good = !ovf && (cs_flip == 8'h00);
    send_byte(8'hA5, gap);
    send_byte(cnt[23:16], gap);
    send_byte(cnt[15:8], gap);
    send_byte(cnt[7:0], gap);
    if (ovf) begin
      check("ovf_error_now", 64'(error),    64'd1);
      check("ovf_in_ready",  64'(in_ready), 64'd0);
    end else begin
      for (int w = 0; w < int'(cnt); w++) begin
        wd = frame_words[w];
        exp_addr_q.push_back(64'(w));
        exp_data_q.push_back(wd);
        for (int b = 7; b >= 0; b--) begin
          by = wd[b*8 +: 8];
          cs = cs ^ by;
          send_byte(by, gap);
        end
      end
      send_byte(cs ^ cs_flip, gap);
    end
    repeat (2) idle();
    // Bytes offered after the frame must be refused and cause no writes.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 8'hA5 : 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle();
    check("end_run",      64'(run),      good ? 64'd1 : 64'd0);
    check("end_error",    64'(error),    good ? 64'd0 : 64'd1);
    check("end_in_ready", 64'(in_ready), 64'd0);
    check("pending_writes", 64'(exp_data_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] flip;
    int         n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk); #1;
    do_reset();

    // Leading junk then one word, correct checksum 0x08.
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    frame_words = '{64'h0102030405060708};
    run_frame(24'd1, 8'h00, 0);
    do_reset();

    // Two words with in_valid toggling every other cycle.
    frame_words = '{64'h1111111111111111, 64'h2222222222222222};
    run_frame(24'd2, 8'h00, 1);
    do_reset();

    // Wrong checksum (0x09 instead of 0x08): write survives, frame rejected.
    frame_words = '{64'h0102030405060708};
    run_frame(24'd1, 8'h01, 0);
    do_reset();

    // Empty program.
    frame_words.delete();
    run_frame(24'd0, 8'h00, 0);
    do_reset();

    // Counts beyond the addressable range.
    run_frame(24'h100001, 8'h00, 0);
    do_reset();
    run_frame(24'hFFFFFF, 8'h00, -1);
    do_reset();

    // Reset in the middle of a word, then a fresh frame.
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 5; i++) send_byte(8'hEE, 0);
    do_reset();
    frame_words = '{64'hDEADBEEF01234567};
    run_frame(24'd1, 8'h00, 0);
    do_reset();

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      send_junk(int'($urandom_range(0, 3)));
      n = int'($urandom_range(0, 4));
      frame_words.delete();
      for (int w = 0; w < n; w++) frame_words.push_back({$urandom, $urandom});
      flip = 8'h00;
      if ($urandom_range(0, 3) == 0) flip = 8'($urandom_range(1, 255));
      run_frame(24'(n), flip, -1);
      do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 64, meaning instruction word width; fixed at 64 (8 bytes).
REQ-002 SHALL have parameter ADDR_W, default 20, meaning program-memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  incoming byte stream.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-008 SHALL have port wr_en  output  1  program-memory write strobe.
REQ-009 SHALL have port wr_addr  output  ADDR_W  program-memory write address.
REQ-010 SHALL have port wr_data  output  WORD_W  instruction word to write.
REQ-011 SHALL have port run  output  1  processor may fetch (pc advance enable); high only after a verified load.
REQ-012 SHALL have port error  output  1  frame rejected; sticky.

Function
REQ-013 Frame format SHALL be: sync byte 0xA5, 3-byte count N (MSB first), N×8 instruction bytes (MSB first per word), 1 checksum byte.
REQ-014 States SHALL be SYNC, LEN, DATA, CHECK, DONE, ERR.
REQ-015 SYNC: accepted byte 0xA5 -> LEN; any other byte SHALL be discarded, state unchanged.
REQ-016 LEN: after 3rd accepted byte, N==0 -> CHECK; N > 2^ADDR_W -> ERR; otherwise -> DATA.
REQ-017 DATA: each 8 accepted bytes SHALL form one word, first byte in bits [63:56], 8th byte in [7:0].
REQ-018 wr_en SHALL pulse high exactly 1 cycle, in the cycle after the 8th byte of a word is accepted, with wr_data = that word and wr_addr = word index (0 for first word).
REQ-019 After word N-1 is accepted -> CHECK.
REQ-020 Checksum SHALL be XOR of all N×8 instruction bytes (0x00 when N==0); count and sync bytes excluded.
REQ-021 CHECK: accepted byte equal to checksum -> DONE; unequal -> ERR.
REQ-022 in_ready SHALL be high in SYNC, LEN, DATA, CHECK and low in DONE, ERR; no backpressure while loading.
REQ-023 run SHALL be high iff state is DONE; error SHALL be high iff state is ERR.
REQ-024 DONE and ERR SHALL be terminal; only rst exits them.
REQ-025 Bytes presented with in_valid low SHALL have no effect; in_valid may drop mid-word without losing partial word.
REQ-026 wr_en SHALL never assert outside DATA-derived writes; words already written before an ERR are not retracted, but run stays low.
REQ-027 Word index counter SHALL be ADDR_W+1 bits internally so N = 2^ADDR_W is representable; last write address 2^ADDR_W-1.

Reset
REQ-028 rst high at a rising edge SHALL force state SYNC, clear byte/word counters, count, checksum, and partial word, regardless of current state (including mid-word).
REQ-029 During and in the cycle after reset: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, run=0, error=0.
REQ-030 A byte presented in the same cycle as rst high SHALL be ignored.

Verification
REQ-031 Stream 0x00,0x13,0xA5,0x00,0x00,0x01, bytes 01..08, checksum 0x08 -> one wr_en, wr_addr=0, wr_data=0x0102030405060708, then run=1, in_ready=0.
REQ-032 N=2, words 0x1111111111111111 and 0x2222222222222222, checksum 0x00, in_valid toggled every other cycle -> wr_en at addr 0 then 1 with those data, run=1.
REQ-033 N=1, bytes 01..08, checksum 0x09 -> wr_en once at addr 0, then error=1, run=0, in_ready=0.
REQ-034 Frame 0xA5,0x00,0x00,0x00,0x00 -> no wr_en, run=1.
REQ-035 Count 0x100001 with ADDR_W=20 -> error=1 immediately after 3rd count byte, no wr_en.
REQ-036 rst asserted after 5th byte of first word, then valid N=1 frame -> single write with wr_addr=0 and only new-frame bytes in wr_data, run=1.
